lenvelope_detector: RTL and testbench

//  Peak envelope follower with attack/hold/release ballistics; stage directly upstream of the limiter-compressor.

---
 rtl/lenvelope_detector_if.sv | 30 +++
 rtl/lenvelope_detector.sv | 154 +++++++++++++++
 tb/tb_lenvelope_detector.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lenvelope_detector_if.sv
// Sample bus between the envelope follower and its neighbours.
// Inputs: i_ce, i_data. Outputs: o_ce, o_data, o_envelope, o_state.
interface lenvelope_detector_if #(
  parameter int W_TOTAL = 16
);
  logic               i_ce;
  logic [W_TOTAL-1:0] i_data;
  logic               o_ce;
  logic [W_TOTAL-1:0] o_data;
  logic [W_TOTAL-1:0] o_envelope;
  logic [1:0]         o_state;

  modport master (
    output i_ce,
    output i_data,
    input  o_ce,
    input  o_data,
    input  o_envelope,
    input  o_state
  );

  modport slave (
    input  i_ce,
    input  i_data,
    output o_ce,
    output o_data,
    output o_envelope,
    output o_state
  );
endinterface

// File: rtl/lenvelope_detector.sv
// Peak envelope follower (attack/hold/release), 2 strobe stages.
// Ports: i_clk, i_reset_n (async low), bus (slave: i_ce/i_data in,
// o_ce/o_data/o_envelope/o_state out). Macro LENVELOPE_HOLD_EN
// enables the HOLD state and hold counter.
module lenvelope_detector #(
  parameter int W_TOTAL       = 16,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int HOLD_SAMPLES  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  lenvelope_detector_if.slave  bus
);

  localparam logic [W_TOTAL-1:0] MAXPOS =
    {1'b0, {(W_TOTAL-1){1'b1}}};
  localparam logic [W_TOTAL-1:0] ONE =
    W_TOTAL'(1);

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  // stage 1
  logic               s1_vld_q;
  logic [W_TOTAL-1:0] s1_mag_q;
  logic [W_TOTAL-1:0] s1_mag_d;
  logic [W_TOTAL-1:0] s1_data_q;
  logic [W_TOTAL-1:0] abs_v;

  // stage 2
  logic               o_ce_q;
  logic [W_TOTAL-1:0] o_data_q;
  logic [W_TOTAL-1:0] env_q;
  logic [W_TOTAL-1:0] env_d;
  state_e             state_q;
  state_e             state_d;

  logic [W_TOTAL-1:0] up;
  logic [W_TOTAL-1:0] dn;
  logic [W_TOTAL-1:0] a_step;
  logic [W_TOTAL-1:0] r_step;

  // Only the most negative code negates onto the sign bit.
  always_comb begin
    abs_v = bus.i_data;
    if (bus.i_data[W_TOTAL-1])
      abs_v = ~bus.i_data + ONE;
    s1_mag_d = abs_v[W_TOTAL-1] ? MAXPOS : abs_v;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_mag_q  <= '0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= bus.i_ce;
      if (bus.i_ce) begin
        s1_mag_q  <= s1_mag_d;
        s1_data_q <= bus.i_data;
      end
    end
  end

  assign up     = s1_mag_q - env_q;
  assign dn     = env_q - s1_mag_q;
  assign a_step = up >> ATTACK_SHIFT;
  assign r_step = dn >> RELEASE_SHIFT;

`ifdef LENVELOPE_HOLD_EN
  localparam int HW =
    (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    hold_d  = hold_q;
    unique case (1'b1)
      (s1_mag_q > env_q): begin
        state_d = ST_ATTACK;
        env_d   = env_q + ((a_step == '0) ? ONE : a_step);
        hold_d  = HOLD_INIT;
      end
      (hold_q != '0): begin
        state_d = ST_HOLD;
        hold_d  = hold_q - HW'(1);
      end
      default: begin
        state_d = ST_RELEASE;
        // env==mag gives dn==0, so no step is taken
        env_d   = env_q -
          (((r_step == '0) && (dn != '0)) ? ONE : r_step);
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      hold_q <= '0;
    else if (s1_vld_q)
      hold_q <= hold_d;
  end
`else
  // HOLD_SAMPLES has no effect in this build
  logic unused_hold;
  assign unused_hold = (HOLD_SAMPLES != 0);

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    unique case (1'b1)
      (s1_mag_q > env_q): begin
        state_d = ST_ATTACK;
        env_d   = env_q + ((a_step == '0) ? ONE : a_step);
      end
      default: begin
        state_d = ST_RELEASE;
        env_d   = env_q -
          (((r_step == '0) && (dn != '0)) ? ONE : r_step);
      end
    endcase
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ce_q   <= 1'b0;
      o_data_q <= '0;
      env_q    <= '0;
      state_q  <= ST_RELEASE;
    end else begin
      o_ce_q <= s1_vld_q;
      if (s1_vld_q) begin
        o_data_q <= s1_data_q;
        env_q    <= env_d;
        state_q  <= state_d;
      end
    end
  end

  assign bus.o_ce       = o_ce_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_envelope = env_q;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_lenvelope_detector.sv
// Directed bench for lenvelope_detector.
// Drives the bus interface, checks envelope, state and strobe timing.
module tb_lenvelope_detector;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lenvelope_detector_if #(.W_TOTAL(W)) bus ();

  lenvelope_detector #(
    .W_TOTAL(W),
    .ATTACK_SHIFT(2),
    .RELEASE_SHIFT(8),
    .HOLD_SAMPLES(64)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic        ce_early, ce_hit, ce_late, stable;
  logic [15:0] r_env, r_data;
  logic [1:0]  r_st;

  task automatic do_reset();
    bus.i_ce = 1'b0;
    bus.i_data = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated sample; captures strobe timing and outputs.
  task automatic send_one(input logic [15:0] d);
    @(posedge clk); #1;
    bus.i_ce = 1'b1;
    bus.i_data = d;
    @(posedge clk); #1;
    bus.i_ce = 1'b0;
    ce_early = bus.o_ce;
    @(posedge clk); #1;
    ce_hit = bus.o_ce;
    r_env  = bus.o_envelope;
    r_data = bus.o_data;
    r_st   = bus.o_state;
    @(posedge clk); #1;
    ce_late = bus.o_ce;
    stable = (bus.o_envelope === r_env) &&
             (bus.o_data === r_data) &&
             (bus.o_state === r_st);
  endtask

  task automatic test_reset();
    logic [15:0] e;
    do_reset();
    checks++;
    if (bus.o_ce !== 1'b0 || bus.o_envelope !== 16'd0 ||
        bus.o_data !== 16'd0 || bus.o_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_init ce=%b env=%0d data=%0d st=%0d exp 0",
               bus.o_ce, bus.o_envelope, bus.o_data, bus.o_state);
    end
    @(posedge clk); #1;
    bus.i_data = 16'd16384;
    bus.i_ce = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    e = bus.o_envelope;
    checks++;
    if (e === 16'd0) begin
      errors++;
      $display("FAIL reset_pre_run env=%0d exp nonzero", e);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_ce !== 1'b0 || bus.o_envelope !== 16'd0 ||
        bus.o_data !== 16'd0 || bus.o_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_async ce=%b env=%0d data=%0d st=%0d exp 0",
               bus.o_ce, bus.o_envelope, bus.o_data, bus.o_state);
    end
    bus.i_ce = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_ce !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale_ce cyc=%0d got %b exp 0", c, bus.o_ce);
      end
    end
    send_one(16'd16384);
    checks++;
    if (ce_early !== 1'b0 || ce_hit !== 1'b1 || r_env !== 16'd4096) begin
      errors++;
      $display("FAIL reset_first early=%b ce=%b env=%0d exp 0 1 4096",
               ce_early, ce_hit, r_env);
    end
  endtask

  task automatic test_attack_step();
    logic [15:0] exp3 [3];
    logic [15:0] prev;
    int k;
    exp3[0] = 16'd4096;
    exp3[1] = 16'd7168;
    exp3[2] = 16'd9472;
    do_reset();
    prev = '0;
    k = 0;
    for (int c = 0; c < 52; c++) begin
      @(posedge clk); #1;
      if (c >= 2) begin
        checks++;
        if (bus.o_ce !== 1'b1 || bus.o_data !== 16'd16384) begin
          errors++;
          $display("FAIL attack_ce_data k=%0d ce=%b data=%0d exp 1 16384",
                   k, bus.o_ce, bus.o_data);
        end
        if (k < 3) begin
          checks++;
          if (bus.o_envelope !== exp3[k] || bus.o_state !== 2'd1) begin
            errors++;
            $display("FAIL attack_val k=%0d env=%0d st=%0d exp %0d 1",
                     k, bus.o_envelope, bus.o_state, exp3[k]);
          end
        end
        checks++;
        if (bus.o_envelope < prev || bus.o_envelope > 16'd16384) begin
          errors++;
          $display("FAIL attack_mono k=%0d env=%0d prev=%0d max 16384",
                   k, bus.o_envelope, prev);
        end
        prev = bus.o_envelope;
        k++;
      end
      bus.i_ce = (c < 50);
      bus.i_data = 16'd16384;
    end
    checks++;
    if (prev !== 16'd16384) begin
      errors++;
      $display("FAIL attack_final env=%0d exp 16384", prev);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_ce !== 1'b0) begin
      errors++;
      $display("FAIL attack_ce_end got %b exp 0", bus.o_ce);
    end
  endtask

  task automatic test_full_scale_neg();
    logic [15:0] prev;
    do_reset();
    prev = '0;
    for (int c = 0; c < 72; c++) begin
      @(posedge clk); #1;
      if (c >= 2) begin
        checks++;
        if (bus.o_envelope < prev || bus.o_envelope > 16'd32767 ||
            bus.o_data !== 16'h8000) begin
          errors++;
          $display("FAIL fullneg c=%0d env=%0d prev=%0d data=%h",
                   c, bus.o_envelope, prev, bus.o_data);
        end
        if (c == 2) begin
          checks++;
          if (bus.o_envelope !== 16'd8191 || bus.o_state !== 2'd1) begin
            errors++;
            $display("FAIL fullneg_first env=%0d st=%0d exp 8191 1",
                     bus.o_envelope, bus.o_state);
          end
        end
        prev = bus.o_envelope;
      end
      bus.i_ce = (c < 70);
      bus.i_data = 16'h8000;
    end
    checks++;
    if (prev !== 16'd32767) begin
      errors++;
      $display("FAIL fullneg_final env=%0d exp 32767", prev);
    end
  endtask

  task automatic test_hold_release();
    int n;
    do_reset();
    n = 0;
    r_env = '0;
    while (r_env !== 16'd16384 && n < 100) begin
      send_one(16'd16384);
      n++;
    end
    checks++;
    if (r_env !== 16'd16384 || r_st !== 2'd1) begin
      errors++;
      $display("FAIL hold_reach env=%0d st=%0d exp 16384 1", r_env, r_st);
    end
`ifdef LENVELOPE_HOLD_EN
    for (int i = 0; i < 64; i++) begin
      send_one(16'd0);
      checks++;
      if (ce_hit !== 1'b1 || r_env !== 16'd16384 || r_st !== 2'd2) begin
        errors++;
        $display("FAIL hold_phase i=%0d ce=%b env=%0d st=%0d exp 1 16384 2",
                 i, ce_hit, r_env, r_st);
      end
    end
`endif
    send_one(16'd0);
    checks++;
    if (r_env !== 16'd16320 || r_st !== 2'd0 || r_data !== 16'd0) begin
      errors++;
      $display("FAIL release_1 env=%0d st=%0d data=%0d exp 16320 0 0",
               r_env, r_st, r_data);
    end
    send_one(16'd0);
    checks++;
    if (r_env !== 16'd16257 || r_st !== 2'd0) begin
      errors++;
      $display("FAIL release_2 env=%0d st=%0d exp 16257 0", r_env, r_st);
    end
  endtask

  task automatic test_min_step();
    logic [15:0] up_exp [3];
    logic [15:0] dn_exp [4];
    up_exp[0] = 16'd1;
    up_exp[1] = 16'd2;
    up_exp[2] = 16'd3;
    dn_exp[0] = 16'd2;
    dn_exp[1] = 16'd1;
    dn_exp[2] = 16'd0;
    dn_exp[3] = 16'd0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_one(16'hFFFD);
      checks++;
      if (r_env !== up_exp[i] || r_st !== 2'd1) begin
        errors++;
        $display("FAIL minstep_up i=%0d env=%0d st=%0d exp %0d 1",
                 i, r_env, r_st, up_exp[i]);
      end
    end
`ifdef LENVELOPE_HOLD_EN
    for (int i = 0; i < 64; i++) begin
      send_one(16'd0);
      checks++;
      if (r_env !== 16'd3 || r_st !== 2'd2) begin
        errors++;
        $display("FAIL minstep_hold i=%0d env=%0d st=%0d exp 3 2",
                 i, r_env, r_st);
      end
    end
`endif
    for (int i = 0; i < 4; i++) begin
      send_one(16'd0);
      checks++;
      if (r_env !== dn_exp[i] || r_st !== 2'd0) begin
        errors++;
        $display("FAIL minstep_dn i=%0d env=%0d st=%0d exp %0d 0",
                 i, r_env, r_st, dn_exp[i]);
      end
    end
  endtask

  task automatic test_strobe_gaps();
    logic [15:0] exp6 [6];
    logic [15:0] l_env, l_data;
    logic [1:0]  l_st;
    logic        want;
    int          k;
    exp6[0] = 16'd4096;
    exp6[1] = 16'd7168;
    exp6[2] = 16'd9472;
    exp6[3] = 16'd11200;
    exp6[4] = 16'd12496;
    exp6[5] = 16'd13468;
    do_reset();
    l_env = '0;
    l_data = '0;
    l_st = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      want = (c >= 2) && ((c - 2) % 3 == 0) && ((c - 2) / 3 < 6);
      k = (c - 2) / 3;
      checks++;
      if (bus.o_ce !== want) begin
        errors++;
        $display("FAIL gap_ce c=%0d got %b exp %b", c, bus.o_ce, want);
      end
      if (want) begin
        checks++;
        if (bus.o_envelope !== exp6[k] || bus.o_state !== 2'd1 ||
            bus.o_data !== 16'd16384) begin
          errors++;
          $display("FAIL gap_val k=%0d env=%0d st=%0d data=%0d exp %0d",
                   k, bus.o_envelope, bus.o_state, bus.o_data, exp6[k]);
        end
        l_env = bus.o_envelope;
        l_data = bus.o_data;
        l_st = bus.o_state;
      end else begin
        checks++;
        if (bus.o_envelope !== l_env || bus.o_data !== l_data ||
            bus.o_state !== l_st) begin
          errors++;
          $display("FAIL gap_stable c=%0d env=%0d exp %0d",
                   c, bus.o_envelope, l_env);
        end
      end
      bus.i_ce = ((c % 3) == 0) && (c / 3 < 6);
      bus.i_data = 16'd16384;
    end
  endtask

  task automatic test_isolated_stable();
    do_reset();
    send_one(16'hC000);
    checks++;
    if (ce_early !== 1'b0 || ce_hit !== 1'b1 || ce_late !== 1'b0 ||
        !stable || r_env !== 16'd4096 || r_data !== 16'hC000) begin
      errors++;
      $display("FAIL isolated e=%b c=%b l=%b s=%b env=%0d data=%h",
               ce_early, ce_hit, ce_late, stable, r_env, r_data);
    end
  endtask

  initial begin
    bus.i_ce = 1'b0;
    bus.i_data = '0;
    test_reset();
    test_attack_step();
    test_full_scale_neg();
    test_hold_release();
    test_min_step();
    test_strobe_gaps();
    test_isolated_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
